wb_stage: RTL
=============

# wb_stage

Writeback stage of the five-stage pipeline. Consumes the W-stage register outputs (PC, instruction, ALU result, load data, destination, select, write enable) and holds the 32×32 general register file. Selects the writeback value, commits it to the register file, and bypasses same-cycle writes to the D-stage read ports. Also provides a registered commit trace and a retired-instruction counter for the bench and the debug console.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_3000`: base value; a W-stage PC below it marks a bubble.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `PCW`  in  32  PC of the instruction in W
- `InstrW`  in  32  instruction word in W; `0` is a bubble/nop
- `ResW`  in  32  ALU/shifter result
- `RDW`  in  32  data-memory read data
- `A3W`  in  5  destination register
- `MemtoRegW`  in  2  writeback select
- `RegWriteW`  in  1  register write enable
- `A1`, `A2`  in  5 each  D-stage read addresses
- `RD1`, `RD2`  out  32 each  D-stage read data, with bypass
- `WDW`  out  32  selected writeback value, exported for forwarding to E/M
- `commit_valid`  out  1  registered: a register write happened last cycle
- `commit_pc`  out  32  PC of that write
- `commit_reg`  out  5  register number of that write
- `commit_data`  out  32  value written
- `retire_count`  out  32  count of non-bubble instructions that reached W

## Operation
- Writeback select, combinational:
  - `MemtoRegW` 00 → `ResW`
  - 01 → `RDW`
  - 10 → `PCW + 8` (jal/jalr link; 32-bit wrap, carry dropped)
  - 11 → reserved, behaves as 00
- Write qualifier: `we = RegWriteW && (A3W != 0)`. Register 0 is never written and always reads 0.
- On a rising edge with `we`, `grf[A3W] <= WDW`.
- Read ports, combinational:
  - If `A1 == 0`, `RD1 = 0`.
  - Else if `we && A3W == A1`, `RD1 = WDW` (bypass).
  - Else `RD1 = grf[A1]`.
  - `RD2` follows the same rules with `A2`.
- Commit trace: on each edge, `commit_valid <= we` and the other trace fields latch `PCW`, `A3W`, `WDW`. When `we` is 0 the trace fields hold their previous values.
- Retire counter: increments by 1 on an edge when `InstrW != 0` and `PCW >= RESET_PC`. This applies whether or not the instruction writes a register, e.g. sw and beq. Wraps modulo 2^32.
- Reset, on an edge with `reset` high:
  - all 32 registers ← 0
  - `commit_valid` ← 0 and all trace fields ← 0
  - `retire_count` ← 0
  - Reset takes priority over any concurrent write.
  - The combinational outputs `RD1`, `RD2` and `WDW` still follow their inputs while reset is high.

## Timing
- Write latency: the value is visible in `grf` the cycle after the edge. Same-cycle readers see it through the bypass, so there is 0 effective read-after-write latency for D.
- `commit_*` lags the write by exactly one cycle. `retire_count` reflects an instruction one cycle after it sits in W.
- Reset held N cycles: outputs stay at reset values for N cycles. The first write is accepted on the first edge with `reset` low.
- Simultaneous events:
  - `A1 == A2 == A3W` with `we`: both ports bypass.
  - `A3W == 0` with `RegWriteW`: no write, `commit_valid` 0, retire still counts.

## Structure
- Shared package `mips_pkg` holds:
  - `MemtoReg` encodings: `WB_ALU = 2'b00`, `WB_MEM = 2'b01`, `WB_LINK = 2'b10`
  - `REG_ZERO = 5'd0`
  - `RESET_PC`
- Sub-module `grf`: 32×32 array, one write port, two bypassed read ports, synchronous reset.
- `wb_stage` contains the select mux, the trace registers and the counter.

## Test plan
- Reset for 2 cycles → all `RD` reads return 0, `retire_count` 0, `commit_valid` 0.
- `RegWriteW=1`, `A3W=5`, `MemtoRegW=00`, `ResW=32'hDEAD_BEEF`, `A1=5` in the same cycle → `RD1 = 32'hDEAD_BEEF` immediately. The next cycle gives `commit_valid=1`, `commit_reg=5`, and `RD1` still holds DEADBEEF from the array.
- `MemtoRegW=01`, `RDW=32'h1234`, `A3W=8` → `WDW=32'h1234`. Then `MemtoRegW=10`, `PCW=32'h3010`, `A3W=31` → `grf[31] = 32'h3018`.
- `RegWriteW=1`, `A3W=0`, `ResW=7`, `A1=0` → `RD1=0`, `commit_valid=0` next cycle, `retire_count` increments by 1.
- Sequence of 3 valid instructions (one sw with `RegWriteW=0`), 2 bubbles with `InstrW=0`, then `reset` pulsed with a concurrent write to reg 9 → count reaches 3 before reset. After reset, `grf[9]=0` and `retire_count=0`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and constants for the five-stage MIPS pipeline.
package mips_pkg;
   localparam logic [1:0]  WB_ALU   = 2'b00;
   localparam logic [1:0]  WB_MEM   = 2'b01;
   localparam logic [1:0]  WB_LINK  = 2'b10;
   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/wb_stage_grf.sv
// 32x32 general register file: one write port, two read ports that bypass the
// same-cycle write so D sees a zero read-after-write latency.
module grf
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_i,
   input  logic [4:0]  a3_i,
   input  logic [31:0] wd_i,
   input  logic [4:0]  a1_i,
   input  logic [4:0]  a2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o
);
   logic [31:0] regs_q [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (a3_i != REG_ZERO)) begin
         regs_q[a3_i] <= wd_i;
      end
   end

   always_comb begin
      rd1_o = regs_q[a1_i];
      rd2_o = regs_q[a2_i];
      if (a1_i == REG_ZERO)                rd1_o = '0;
      else if (we_i && (a3_i == a1_i))     rd1_o = wd_i;
      if (a2_i == REG_ZERO)                rd2_o = '0;
      else if (we_i && (a3_i == a2_i))     rd2_o = wd_i;
   end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, commits it to the GRF, and
// keeps a one-cycle-late commit trace plus a retired-instruction counter.
module wb_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCW,
   input  logic [31:0] InstrW,
   input  logic [31:0] ResW,
   input  logic [31:0] RDW,
   input  logic [4:0]  A3W,
   input  logic [1:0]  MemtoRegW,
   input  logic        RegWriteW,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] WDW,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic [4:0]  commit_reg,
   output logic [31:0] commit_data,
   output logic [31:0] retire_count
);
   logic        we;
   logic        retire;
   logic        cvalid_q;
   logic [31:0] cpc_q, cdata_q, retire_q, retire_d;
   logic [4:0]  creg_q;

   always_comb begin
      unique case (MemtoRegW)
         WB_MEM:  WDW = RDW;
         WB_LINK: WDW = PCW + 32'd8;
         default: WDW = ResW;   // 2'b11 is reserved and aliases the ALU path
      endcase
   end

   assign we       = RegWriteW && (A3W != REG_ZERO);
   // Bubbles are either a zero word or a PC below the reset vector.
   assign retire   = (InstrW != '0) && (PCW >= RESET_PC);
   assign retire_d = retire ? retire_q + 32'd1 : retire_q;

   grf u_grf (
      .clk   (clk),
      .reset (reset),
      .we_i  (we),
      .a3_i  (A3W),
      .wd_i  (WDW),
      .a1_i  (A1),
      .a2_i  (A2),
      .rd1_o (RD1),
      .rd2_o (RD2)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cvalid_q <= 1'b0;
         cpc_q    <= '0;
         creg_q   <= '0;
         cdata_q  <= '0;
         retire_q <= '0;
      end else begin
         cvalid_q <= we;
         retire_q <= retire_d;
         if (we) begin
            cpc_q   <= PCW;
            creg_q  <= A3W;
            cdata_q <= WDW;
         end
      end
   end

   assign commit_valid = cvalid_q;
   assign commit_pc    = cpc_q;
   assign commit_reg   = creg_q;
   assign commit_data  = cdata_q;
   assign retire_count = retire_q;
endmodule
